// File: rtl/apb_i2c_regif_pkg.sv
// apb_i2c_regif_pkg: register offsets, FSM state type and IRQ bit indices
package apb_i2c_regif_pkg;
  localparam int unsigned OFS_TXDATA     = 'h00;
  localparam int unsigned OFS_RXDATA     = 'h04;
  localparam int unsigned OFS_CONFIG     = 'h08;
  localparam int unsigned OFS_TIMEOUT    = 'h0C;
  localparam int unsigned OFS_STATUS     = 'h10;
  localparam int unsigned OFS_IRQ_STATUS = 'h14;
  localparam int unsigned OFS_IRQ_MASK   = 'h18;
  localparam int IRQ_TXE = 0;
  localparam int IRQ_RXA = 1;
  localparam int IRQ_ERR = 2;
  localparam int IRQ_W   = 3;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} regif_state_t;
endpackage

// File: rtl/apb_i2c_irq_ctrl.sv
// apb_i2c_irq_ctrl: edge-latched interrupt status with W1C, mask and registered irq
module apb_i2c_irq_ctrl import apb_i2c_regif_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tx_empty,
  input  logic             i_rx_empty,
  input  logic             i_i2c_error,
  input  logic [IRQ_W-1:0] i_w1c,
  input  logic             i_mask_we,
  input  logic [IRQ_W-1:0] i_mask_d,
  output logic [IRQ_W-1:0] o_status,
  output logic [IRQ_W-1:0] o_mask,
  output logic             o_irq
);
  logic r_tx_q, r_rx_q, r_err_q, r_irq;
  logic [IRQ_W-1:0] r_status, r_mask, w_set;
  assign w_set[IRQ_TXE] = i_tx_empty & ~r_tx_q;
  assign w_set[IRQ_RXA] = ~i_rx_empty & r_rx_q;
  assign w_set[IRQ_ERR] = i_i2c_error & ~r_err_q;
  assign o_status = r_status;
  assign o_mask   = r_mask;
  assign o_irq    = r_irq;
  // Sample levels, latch edges (a same-cycle set beats the clear), hold mask, register irq
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx_q   <= 1'b0;
      r_rx_q   <= 1'b0;
      r_err_q  <= 1'b0;
      r_status <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_tx_q   <= i_tx_empty;
      r_rx_q   <= i_rx_empty;
      r_err_q  <= i_i2c_error;
      r_status <= (r_status & ~i_w1c) | w_set;
      if (i_mask_we) r_mask <= i_mask_d;
      r_irq    <= |(r_status & r_mask);
    end
endmodule

// File: rtl/apb_i2c_regif.sv
// apb_i2c_regif: APB3 register slave for the I2C core; APB_I2C_REGIF_PSTRB_EN adds byte strobes
module apb_i2c_regif import apb_i2c_regif_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int CFG_W       = 14,
  parameter int TMO_W       = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSELx,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_I2C_REGIF_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [DATA_W-1:0]   tx_wdata,
  output logic                tx_wr_en,
  input  logic                tx_full,
  input  logic                tx_empty,
  output logic                rx_rd_en,
  input  logic [DATA_W-1:0]   rx_rdata,
  input  logic                rx_empty,
  input  logic                i2c_error,
  output logic [CFG_W-1:0]    cfg_config,
  output logic [TMO_W-1:0]    cfg_timeout,
  output logic                irq
);
  regif_state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [31:0] r_addr;
  logic [ADDR_W-1:0] w_ofs;
  logic [DATA_W-1:0] r_wdata, r_rdata, w_bmask, w_rd;
  logic [IRQ_W-1:0] w_status, w_mask, w_w1c, w_msk_d;
  logic r_write, r_ready, r_err, r_rx;
  logic w_hi_ok, w_tx, w_rx, w_cfg, w_tmo, w_st, w_ist, w_msk, w_err, w_commit, w_wr, w_strb_ok;
`ifdef APB_I2C_REGIF_PSTRB_EN
  logic [DATA_W/8-1:0] r_strb;
  // Capture the byte strobes with the rest of the setup phase
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_strb <= '0;
    else if (r_state == IDLE && w_next == ACCESS) r_strb <= PSTRB;
  // Expand byte strobes into a per-bit write mask
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < DATA_W/8; i++) w_bmask[i*8 +: 8] = {8{r_strb[i]}};
  end
`else
  assign w_bmask = '1;
`endif
  assign w_strb_ok = &w_bmask;
  assign w_ofs   = r_addr[ADDR_W-1:0];
  assign w_hi_ok = (r_addr >> ADDR_W) == 32'd0;
  assign w_tx    = w_hi_ok && w_ofs == ADDR_W'(OFS_TXDATA);
  assign w_rx    = w_hi_ok && w_ofs == ADDR_W'(OFS_RXDATA);
  assign w_cfg   = w_hi_ok && w_ofs == ADDR_W'(OFS_CONFIG);
  assign w_tmo   = w_hi_ok && w_ofs == ADDR_W'(OFS_TIMEOUT);
  assign w_st    = w_hi_ok && w_ofs == ADDR_W'(OFS_STATUS);
  assign w_ist   = w_hi_ok && w_ofs == ADDR_W'(OFS_IRQ_STATUS);
  assign w_msk   = w_hi_ok && w_ofs == ADDR_W'(OFS_IRQ_MASK);
  assign w_err   = !((w_tx && r_write && !tx_full && w_strb_ok) || (w_rx && !r_write && !rx_empty) ||
                     w_cfg || w_tmo || w_ist || w_msk || (w_st && !r_write));
  assign w_commit = r_state == ACCESS && PSELx && r_cnt == 4'd0;
  assign w_wr     = w_commit && r_write && !w_err;
  assign tx_wr_en = w_commit && w_tx && !w_err;
  assign rx_rd_en = w_commit && w_rx && !w_err;
  assign tx_wdata = r_wdata;
  assign w_rd = w_cfg ? DATA_W'(cfg_config) : w_tmo ? DATA_W'(cfg_timeout) :
                w_st  ? DATA_W'({i2c_error, rx_empty, tx_empty}) :
                w_ist ? DATA_W'(w_status) : w_msk ? DATA_W'(w_mask) : '0;
  assign w_w1c   = (w_wr && w_ist) ? r_wdata[IRQ_W-1:0] & w_bmask[IRQ_W-1:0] : '0;
  assign w_msk_d = (w_mask & ~w_bmask[IRQ_W-1:0]) | (r_wdata[IRQ_W-1:0] & w_bmask[IRQ_W-1:0]);
  assign PRDATA  = r_rx ? rx_rdata : r_rdata;
  assign PREADY  = r_ready;
  assign PSLVERR = r_err;
  // Next state: setup starts an access, deselect aborts it, commit moves to the response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (PSELx && !PENABLE) w_next = ACCESS;
      ACCESS:  if (!PSELx) w_next = IDLE; else if (r_cnt == 4'd0) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // State, wait counter, captured transfer and the one-cycle registered response
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rx    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == ACCESS) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
      end else if (r_state == ACCESS && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      r_ready <= w_commit;
      r_err   <= w_commit && w_err;
      r_rx    <= rx_rd_en;
      r_rdata <= (w_commit && !r_write && !w_err) ? w_rd : '0;
    end
  // Configuration registers, written at commit in the enabled byte lanes
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      cfg_config  <= '0;
      cfg_timeout <= '0;
    end else begin
      if (w_wr && w_cfg) cfg_config  <= (cfg_config & ~w_bmask[CFG_W-1:0]) | (r_wdata[CFG_W-1:0] & w_bmask[CFG_W-1:0]);
      if (w_wr && w_tmo) cfg_timeout <= (cfg_timeout & ~w_bmask[TMO_W-1:0]) | (r_wdata[TMO_W-1:0] & w_bmask[TMO_W-1:0]);
    end
  apb_i2c_irq_ctrl u_irq (
    .clk         (PCLK),
    .rst_n       (PRESETn),
    .i_tx_empty  (tx_empty),
    .i_rx_empty  (rx_empty),
    .i_i2c_error (i2c_error),
    .i_w1c       (w_w1c),
    .i_mask_we   (w_wr && w_msk),
    .i_mask_d    (w_msk_d),
    .o_status    (w_status),
    .o_mask      (w_mask),
    .o_irq       (irq)
  );
endmodule
